// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types, constants and round-robin pick function for adder_arbiter
package adder_arb_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    localparam int WIDTH_DEF = 8;
    localparam int MAX_REQ = 8;
    // Valid vectors narrower than MAX_REQ are zero-padded; the padding is never
    // picked, so searching modulo MAX_REQ equals searching modulo NUM_REQ.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] r;
        logic found;
        r = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = ptr + 3'(i);
            if (!found && valid[idx]) begin
                r = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/adder_arbiter_add.sv
// adder_arbiter_add: combinational unsigned adder with carry out
//   sum  out WIDTH  a+b modulo 2^WIDTH
//   cout out 1      carry out
//   a, b in  WIDTH  operands
module adder_arbiter_add #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin shared registered adder with tagged valid/ready responses
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/a/b        per-requester operands, packed [i*WIDTH +: WIDTH]
//   req_ready            one-hot accept strobe (IDLE only)
//   rsp_valid/ready      response handshake
//   rsp_sum/cout/id      result, carry and owning requester index
// Optional: define ADDER_ARB_SAT_EN for a saturating sum on carry.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id
);
    state_t state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, gnt_q, gnt_d, rsp_id_q, rsp_id_d, pick_id;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rsp_sum_q, rsp_sum_d, add_sum, sum_fin;
    logic rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d, add_cout;
    logic [NUM_REQ-1:0] ready_c;
    logic [MAX_REQ-1:0] valid_pad;

    assign valid_pad = MAX_REQ'(req_valid);
    assign pick_id = ID_W'(rr_pick(valid_pad, 3'(ptr_q)));

    adder_arbiter_add #(.WIDTH(WIDTH)) u_add (
        .sum (add_sum),
        .cout(add_cout),
        .a   (a_q),
        .b   (b_q)
    );

`ifdef ADDER_ARB_SAT_EN
    assign sum_fin = add_cout ? '1 : add_sum;
`else
    assign sum_fin = add_sum;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        a_d = a_q;
        b_d = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d = rsp_id_q;
        ready_c = '0;
        case (state_q)
            IDLE: if (|req_valid) begin
                ready_c = NUM_REQ'(1) << pick_id;
                gnt_d = pick_id;
                a_d = req_a[int'(pick_id)*WIDTH +: WIDTH];
                b_d = req_b[int'(pick_id)*WIDTH +: WIDTH];
                state_d = CALC;
            end
            CALC: begin
                rsp_sum_d = sum_fin;
                rsp_cout_d = add_cout;
                rsp_id_d = gnt_q;
                rsp_valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                ptr_d = (gnt_q == ID_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            gnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            a_q <= a_d;
            b_q <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    // No accept strobe while reset is held, even if requesters are valid.
    assign req_ready = rst_n ? ready_c : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum = rsp_sum_q;
    assign rsp_cout = rsp_cout_q;
    assign rsp_id = rsp_id_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed table vectors plus corner sequences and a seeded random scoreboard
module tb_adder_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0] req_ready;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [7:0] rsp_sum;
    logic rsp_cout;
    logic [1:0] rsp_id;
    int checks = 0;
    int errors = 0;

    adder_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout),
        .rsp_id   (rsp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    typedef struct {
        int         port;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat_adj(input logic [7:0] s, input logic c);
`ifdef ADDER_ARB_SAT_EN
        return c ? 8'hFF : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[8], sat_adj(s[7:0], s[8])};
    endfunction

    task automatic set_req(input int p, input logic v, input logic [7:0] a, input logic [7:0] b);
        req_valid[p] = v;
        req_a[p*8 +: 8] = a;
        req_b[p*8 +: 8] = b;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready == 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) chk({name, "_timeout"}, 0, 1);
    endtask

    // Called at posedge+1 in IDLE with rsp_ready=1; ends at posedge+1 back in IDLE.
    task automatic txn(input vec_t v);
        set_req(v.port, 1'b1, v.a, v.b);
        #1;
        wait_ready("txn");
        chk("txn_grant", req_ready, 32'(1) << v.port);
        @(posedge clk); #1;
        req_valid[v.port] = 1'b0;
        chk("txn_calc_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("txn_rsp_valid", rsp_valid, 1);
        chk("txn_sum", rsp_sum, sat_adj(v.sum, v.cout));
        chk("txn_cout", rsp_cout, v.cout);
        chk("txn_id", rsp_id, v.port);
        @(posedge clk); #1;
        chk("txn_done", rsp_valid, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[8];
    logic [11:0] q[$];
    logic [31:0] r;
    logic [11:0] got, want;
    logic [8:0] m;
    logic [3:0] acc;
    int seed = 32'h1234;
    int resp;

    initial begin
        tbl[0] = '{0, 8'h3C, 8'h45, 8'h81, 1'b0};
        tbl[1] = '{2, 8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[2] = '{1, 8'h80, 8'h80, 8'h00, 1'b1};
        tbl[3] = '{3, 8'h12, 8'h34, 8'h46, 1'b0};
        tbl[4] = '{1, 8'h7F, 8'h01, 8'h80, 1'b0};
        tbl[5] = '{0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        tbl[6] = '{3, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{2, 8'hA5, 8'h5A, 8'hFF, 1'b0};

        // reset state, with a requester valid during reset
        req_valid = 4'b0001;
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_id", rsp_id, 0);
        do_reset();

        for (int i = 0; i < 8; i++) txn(tbl[i]);

        // only the just-served requester valid: granted again in the first IDLE cycle
        set_req(1, 1'b1, 8'h01, 8'h02);
        #1;
        wait_ready("rep");
        chk("rep_grant1", req_ready, 4'b0010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rep_sum1", rsp_sum, 8'h03);
        @(posedge clk); #1;
        chk("rep_grant2", req_ready, 4'b0010);
        req_valid = '0;
        @(posedge clk); #1;

        // full load from reset: order 0,1,2,3,0
        do_reset();
        for (int p = 0; p < 4; p++) set_req(p, 1'b1, 8'h10 + 8'(p), 8'h20);
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_ready("load");
            chk("load_grant", req_ready, 32'(1) << (k % 4));
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("load_id", rsp_id, k % 4);
            chk("load_sum", rsp_sum, 8'h30 + 8'(k % 4));
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(posedge clk); #1;

        // backpressure: pointer is 1 so requester 3 wins over 0
        rsp_ready = 1'b0;
        set_req(3, 1'b1, 8'h10, 8'h20);
        set_req(0, 1'b1, 8'h01, 8'h02);
        #1;
        wait_ready("bp");
        chk("bp_grant", req_ready, 4'b1000);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid0", rsp_valid, 1);
        chk("bp_sum0", rsp_sum, 8'h30);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold", {rsp_valid, rsp_cout, rsp_id, rsp_sum, req_ready}, {1'b1, 1'b0, 2'd3, 8'h30, 4'b0000});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("bp_sum1", {rsp_id, rsp_sum}, {2'd0, 8'h03});
        @(posedge clk); #1;

        // reset while in CALC; pointer was 1, so without a pointer reset 3 would win
        set_req(2, 1'b1, 8'h55, 8'h11);
        #1;
        wait_ready("rc");
        chk("rc_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        set_req(0, 1'b1, 8'h01, 8'h01);
        set_req(3, 1'b1, 8'h02, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("rc_outs", {rsp_valid, rsp_cout, rsp_sum, req_ready}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rc_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rc_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("rc_no_rsp2", rsp_valid, 0);
        @(posedge clk); #1;
        chk("rc_rsp", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd0, 8'h02});
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // seeded random traffic checked against a reference model
        resp = 0;
        for (int cyc = 0; cyc < 6000 && resp < 200; cyc++) begin
            @(negedge clk);
            chk("rnd_onehot", 32'($onehot0(req_ready)), 1);
            acc = req_ready;
            for (int p = 0; p < 4; p++) if (req_ready[p]) begin
                m = model(req_a[p*8 +: 8], req_b[p*8 +: 8]);
                q.push_back({1'b0, 2'(p), m});
            end
            if (rsp_valid && rsp_ready) begin
                got = {1'b0, rsp_id, rsp_cout, rsp_sum};
                if (q.size() == 0) chk("rnd_unexpected", got, 12'hFFF);
                else begin
                    want = q.pop_front();
                    chk("rnd_rsp", got, want);
                end
                resp++;
            end
            @(posedge clk); #1;
            for (int p = 0; p < 4; p++) if (acc[p] || !req_valid[p]) begin
                r = $random(seed);
                set_req(p, r[0], r[15:8], r[23:16]);
            end
            r = $random(seed);
            rsp_ready = r[1] | r[2];
        end
        if (resp < 200) chk("rnd_count", resp, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
